tl_phase_scheduler: RTL and testbench

- Intersection phase scheduler for the highway/farm-road crossing.
- Sequences highway green/yellow, farm green/yellow and a pedestrian WALK phase.
- Arbitrates round-robin between farm-road sensor and pedestrian requests, with emergency preemption that holds or returns the highway to green.
- Drives the light lines directly; cycle counts are programmable through parameters.

---
 rtl/tl_pkg.sv | 20 ++
 rtl/tl_phase_timer.sv | 24 ++
 rtl/tl_phase_scheduler.sv | 118 +++++++++++
 tb/tb_tl_phase_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared types and constants for the intersection phase scheduler.
// State encodings, light encodings and grant identifiers.
package tl_pkg;

  typedef enum logic [2:0] {
    HG   = 3'd0,
    HY   = 3'd1,
    FG   = 3'd2,
    FY   = 3'd3,
    WALK = 3'd4
  } phase_e;

  localparam logic [2:0] LIGHT_GRN = 3'b001;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_RED = 3'b100;

  localparam logic FARM = 1'b0;
  localparam logic PED  = 1'b1;

endpackage

// File: rtl/tl_phase_timer.sv
// Phase dwell counter: clears on a phase change, otherwise saturating count.
// Ports: clk, rst (async active-low), clr (sync clear), cnt (count value).
module tl_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tl_phase_scheduler.sv
// Highway/farm-road phase scheduler with pedestrian WALK and emergency preempt.
// In: clk, rst, sensor, ped_req, emg. Out: l_high, l_f, walk, ped_pending, phase.
module tl_phase_scheduler
  import tl_pkg::*;
#(
  parameter int HG_MIN = 20,
  parameter int YEL_T  = 4,
  parameter int FG_MAX = 12,
  parameter int WALK_T = 8,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor,
  input  logic       ped_req,
  input  logic       emg,
  output logic [2:0] l_high,
  output logic [2:0] l_f,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] HG_LAST   = CNT_W'(HG_MIN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YEL_T - 1);
  localparam logic [CNT_W-1:0] FG_LAST   = CNT_W'(FG_MAX - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);

  phase_e           state, state_d;
  logic             grant, grant_d;
  logic             last_grant, last_d;
  logic             pend_clr;
  logic             pend_d;
  logic [CNT_W-1:0] cnt;

  tl_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state_d != state),
    .cnt(cnt)
  );

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    last_d   = last_grant;
    pend_clr = 1'b0;
    l_high   = LIGHT_RED;
    l_f      = LIGHT_RED;
    walk     = 1'b0;
    unique case (state)
      HG: begin
        l_high = LIGHT_GRN;
        if (!emg && cnt >= HG_LAST && (sensor || ped_pending)) begin
          state_d = HY;
          // Contention alternates; a lone requester always wins.
          if (sensor && ped_pending) grant_d = ~last_grant;
          else                       grant_d = ped_pending ? PED : FARM;
        end
      end
      HY: begin
        l_high = LIGHT_YEL;
        if (cnt == YEL_LAST) begin
          // Preempt returns to HG and leaves the pending request latched.
          if (emg) begin
            state_d = HG;
          end else begin
            last_d = grant;
            if (grant == PED) begin
              state_d  = WALK;
              pend_clr = 1'b1;
            end else begin
              state_d = FG;
            end
          end
        end
      end
      FG: begin
        l_f = LIGHT_GRN;
        if (cnt == FG_LAST || !sensor || emg) state_d = FY;
      end
      FY: begin
        l_f = LIGHT_YEL;
        if (cnt == YEL_LAST) state_d = HG;
      end
      WALK: begin
        walk = 1'b1;
        if (cnt == WALK_LAST || emg) state_d = HG;
      end
      default: state_d = HG;
    endcase
  end

  always_comb begin
    pend_d = ped_pending;
    if (pend_clr)                      pend_d = 1'b0;
    else if (ped_req && state != WALK) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= HG;
      grant       <= FARM;
      last_grant  <= FARM;
      ped_pending <= 1'b0;
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      last_grant  <= last_d;
      ped_pending <= pend_d;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Directed self-checking bench for tl_phase_scheduler.
// Phase lengths are measured in cycles by sampling on the falling edge.
module tb_tl_phase_scheduler;
  import tl_pkg::*;

  logic       clk;
  logic       rst;
  logic       sensor;
  logic       ped_req;
  logic       emg;
  logic [2:0] l_high;
  logic [2:0] l_f;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  int n_chk;
  int n_err;

  tl_phase_scheduler dut (
    .clk(clk),
    .rst(rst),
    .sensor(sensor),
    .ped_req(ped_req),
    .emg(emg),
    .l_high(l_high),
    .l_f(l_f),
    .walk(walk),
    .ped_pending(ped_pending),
    .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Measures how many falling-edge samples the current phase lasts.
  // Returns at the first sample of the following phase.
  task automatic run_phase(output logic [2:0] ph, output int len);
    ph  = phase;
    len = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (phase != ph) break;
      len++;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    sensor  = 1'b0;
    ped_req = 1'b0;
    emg     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (phase !== 3'd0 || l_high !== 3'b001 || l_f !== 3'b100
        || walk !== 1'b0 || ped_pending !== 1'b0) begin
      n_err++;
      $display("FAIL reset: phase=%0d lh=%b lf=%b walk=%b pp=%b req 0/001/100/0/0",
               phase, l_high, l_f, walk, ped_pending);
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n_chk++;
      if (phase !== 3'd0 || l_high !== 3'b001 || l_f !== 3'b100 || walk !== 1'b0) begin
        n_err++;
        $display("FAIL idle[%0d]: phase=%0d lh=%b lf=%b walk=%b req HG/001/100/0",
                 i, phase, l_high, l_f, walk);
      end
    end
  endtask

  task automatic test_sensor_cycle();
    logic [2:0] ph;
    int len;
    logic [2:0] exp_ph [6];
    int exp_len [6];
    exp_ph  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
    // HG already ran 5 cycles before the sensor rose.
    exp_len = '{15, 4, 12, 4, 20, 4};
    do_reset();
    repeat (5) @(negedge clk);
    sensor = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        n_chk++;
        if (l_high !== 3'b100 || l_f !== 3'b001) begin
          n_err++;
          $display("FAIL fg_lights: lh=%b lf=%b req 100/001", l_high, l_f);
        end
      end
      run_phase(ph, len);
      n_chk++;
      if (ph !== exp_ph[k] || len !== exp_len[k]) begin
        n_err++;
        $display("FAIL sensor_cycle[%0d]: phase=%0d len=%0d req %0d/%0d",
                 k, ph, len, exp_ph[k], exp_len[k]);
      end
    end
  endtask

  // Entered at the first FG sample left by test_sensor_cycle.
  task automatic test_async_reset();
    n_chk++;
    if (phase !== 3'd2) begin
      n_err++;
      $display("FAIL async_pre: phase=%0d req 2", phase);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (phase !== 3'd0 || l_high !== 3'b001 || l_f !== 3'b100) begin
      n_err++;
      $display("FAIL async_reset: phase=%0d lh=%b lf=%b req 0/001/100",
               phase, l_high, l_f);
    end
    @(negedge clk);
    rst    = 1'b1;
    sensor = 1'b0;
  endtask

  task automatic test_ped_grant();
    logic [2:0] ph;
    int len;
    do_reset();
    sensor  = 1'b1;
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    n_chk++;
    if (ped_pending !== 1'b1) begin
      n_err++;
      $display("FAIL ped_latch: pp=%b req 1", ped_pending);
    end
    run_phase(ph, len);
    n_chk++;
    if (ph !== 3'd0 || len !== 19) begin
      n_err++;
      $display("FAIL ped_hg: phase=%0d len=%0d req 0/19", ph, len);
    end
    run_phase(ph, len);
    n_chk++;
    if (ph !== 3'd1 || len !== 4) begin
      n_err++;
      $display("FAIL ped_hy: phase=%0d len=%0d req 1/4", ph, len);
    end
    n_chk++;
    if (phase !== 3'd4 || walk !== 1'b1 || l_high !== 3'b100
        || l_f !== 3'b100 || ped_pending !== 1'b0) begin
      n_err++;
      $display("FAIL ped_walk: phase=%0d walk=%b lh=%b lf=%b pp=%b req 4/1/100/100/0",
               phase, walk, l_high, l_f, ped_pending);
    end
    run_phase(ph, len);
    n_chk++;
    if (ph !== 3'd4 || len !== 8) begin
      n_err++;
      $display("FAIL walk_len: phase=%0d len=%0d req 4/8", ph, len);
    end
    run_phase(ph, len);
    run_phase(ph, len);
    n_chk++;
    if (ph !== 3'd1 || phase !== 3'd2) begin
      n_err++;
      $display("FAIL farm_next: prev=%0d now=%0d req 1/2", ph, phase);
    end
  endtask

  // Entered at the first FG sample left by test_ped_grant.
  task automatic test_sensor_drop();
    logic [2:0] ph;
    int len;
    repeat (5) @(negedge clk);
    sensor = 1'b0;
    @(negedge clk);
    n_chk++;
    if (phase !== 3'd3 || l_f !== 3'b010) begin
      n_err++;
      $display("FAIL sensor_drop: phase=%0d lf=%b req 3/010", phase, l_f);
    end
    run_phase(ph, len);
    n_chk++;
    if (ph !== 3'd3 || len !== 4 || phase !== 3'd0) begin
      n_err++;
      $display("FAIL fy_len: phase=%0d len=%0d next=%0d req 3/4/0", ph, len, phase);
    end
  endtask

  // Entered at the first HG sample left by test_sensor_drop.
  task automatic test_walk_ignore();
    logic [2:0] ph;
    int len;
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    run_phase(ph, len);
    run_phase(ph, len);
    n_chk++;
    if (phase !== 3'd4) begin
      n_err++;
      $display("FAIL ped_only: phase=%0d req 4", phase);
    end
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    n_chk++;
    if (ped_pending !== 1'b0) begin
      n_err++;
      $display("FAIL walk_ignore: pp=%b req 0", ped_pending);
    end
    run_phase(ph, len);
    repeat (30) @(negedge clk);
    n_chk++;
    if (phase !== 3'd0 || ped_pending !== 1'b0) begin
      n_err++;
      $display("FAIL post_walk: phase=%0d pp=%b req 0/0", phase, ped_pending);
    end
  endtask

  task automatic test_emg();
    logic [2:0] ph;
    int len;
    do_reset();
    sensor = 1'b1;
    run_phase(ph, len);
    run_phase(ph, len);
    repeat (3) @(negedge clk);
    emg = 1'b1;
    @(negedge clk);
    n_chk++;
    if (phase !== 3'd3) begin
      n_err++;
      $display("FAIL emg_fg: phase=%0d req 3", phase);
    end
    run_phase(ph, len);
    n_chk++;
    if (len !== 4 || phase !== 3'd0) begin
      n_err++;
      $display("FAIL emg_fy: len=%0d next=%0d req 4/0", len, phase);
    end
    repeat (40) @(negedge clk);
    n_chk++;
    if (phase !== 3'd0 || l_high !== 3'b001) begin
      n_err++;
      $display("FAIL emg_hold: phase=%0d lh=%b req 0/001", phase, l_high);
    end
    emg = 1'b0;
    @(negedge clk);
    n_chk++;
    if (phase !== 3'd1) begin
      n_err++;
      $display("FAIL emg_release: phase=%0d req 1", phase);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    test_reset();
    test_idle();
    test_sensor_cycle();
    test_async_reset();
    test_ped_grant();
    test_sensor_drop();
    test_walk_ignore();
    test_emg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
